conv_mac_engine: RTL and testbench



---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_mac_engine_if.sv | 45 ++++
 rtl/conv_mac_pipe.sv | 74 +++++++
 rtl/conv_mac_engine.sv | 123 ++++++++++++
 tb/tb_conv_mac_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC engine: default widths, control
// word layout and FSM state encoding.
package conv_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 7;
    localparam int ACC_W_DEF      = 32;
    localparam int SIZE_W         = 7;
    localparam int CTRL_W         = 32;
    localparam int CTRL_START_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_mac_engine_if.sv
// Signal bundle between the MAC engine, the register slave and the operand buffers.
// The master modport is the engine's view of the bundle; the slave modport is its surroundings.
interface conv_mac_engine_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);

    logic [SIZE_W-1:0]        SIZE;
    logic [CTRL_W-1:0]        CONTROL;
    logic                     buf_rd_en;
    logic [ADDR_W-1:0]        buf_rd_addr;
    logic signed [DATA_W-1:0] data_rdata;
    logic signed [DATA_W-1:0] weight_rdata;
    logic [ACC_W-1:0]         SUM;
    logic                     busy;
    logic                     done;

    modport master (
        input  SIZE,
        input  CONTROL,
        input  data_rdata,
        input  weight_rdata,
        output buf_rd_en,
        output buf_rd_addr,
        output SUM,
        output busy,
        output done
    );

    modport slave (
        output SIZE,
        output CONTROL,
        output data_rdata,
        output weight_rdata,
        input  buf_rd_en,
        input  buf_rd_addr,
        input  SUM,
        input  busy,
        input  done
    );

endinterface

// File: rtl/conv_mac_pipe.sv
// Multiply-accumulate datapath: operand-arrival valid, S1 signed product register,
// S2 wrapping accumulator with synchronous clear.
module conv_mac_pipe
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_vld,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic signed [DATA_W-1:0] i_weight,
    output logic                     o_vld_p0,
    output logic                     o_vld_p1,
    output logic signed [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic                     r_vld_p0;
    logic                     r_vld_p1;
    logic signed [PROD_W-1:0] r_prod_p1;
    logic signed [ACC_W-1:0]  r_acc_p2;

    function automatic logic signed [PROD_W-1:0] mul_s(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] ax;
        logic signed [PROD_W-1:0] bx;
        ax = PROD_W'(a);
        bx = PROD_W'(b);
        return ax * bx;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return ACC_W'(p);
    endfunction

    // S0 -> S1: operands land one cycle after the read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p0 <= i_vld;
            r_vld_p1 <= r_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_vld_p0) begin
            r_prod_p1 <= mul_s(i_data, i_weight);
        end
    end

    // S1 -> S2: accumulate, wrapping modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_acc_p2 <= '0;
        end else if (r_vld_p1) begin
            r_acc_p2 <= r_acc_p2 + sext_prod(r_prod_p1);
        end
    end

    assign o_vld_p0 = r_vld_p0;
    assign o_vld_p1 = r_vld_p1;
    assign o_acc    = r_acc_p2;

endmodule

// File: rtl/conv_mac_engine.sv
// Dot-product engine: detects a start edge on CONTROL[0], streams SIZE operand pairs
// from the buffers through the MAC pipe and publishes the result on SUM.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    conv_mac_engine_if.master bus
);

    state_t              r_state;
    state_t              w_next;
    logic                r_ctrl0_q;
    logic [SIZE_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [ACC_W-1:0]    r_sum;

    logic                w_start_pulse;
    logic                w_accept;
    logic                w_rd_en;
    logic                w_cnt_inc;
    logic                w_vld_p0;
    logic                w_vld_p1;
    logic [ADDR_W-1:0]   w_last_addr;
    logic signed [ACC_W-1:0] w_acc;
    logic                w_unused_ctrl;

    assign w_start_pulse = bus.CONTROL[CTRL_START_BIT] & ~r_ctrl0_q;
    assign w_accept      = w_start_pulse && (r_state == IDLE || r_state == DONE);
    assign w_last_addr   = ADDR_W'(r_len) - ADDR_W'(1);
    assign w_unused_ctrl = ^bus.CONTROL[CTRL_W-1:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_rd_en   = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_pulse) begin
                    w_next = (bus.SIZE != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                w_rd_en = 1'b1;
                if (r_cnt == w_last_addr) begin
                    w_next = DRAIN;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                // Accumulator already holds the last term once both upstream stages are empty
                if (!w_vld_p0 && !w_vld_p1) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl0_q <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
        end else begin
            r_ctrl0_q <= bus.CONTROL[CTRL_START_BIT];
            r_busy    <= (w_next == FETCH) || (w_next == DRAIN);
            r_done    <= (w_next == DONE);
            if (w_accept) begin
                r_len <= bus.SIZE;
                r_cnt <= '0;
                r_sum <= '0;
            end else begin
                if (w_cnt_inc) begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                end
                if (r_state == DRAIN && w_next == DONE) begin
                    r_sum <= $unsigned(w_acc);
                end
            end
        end
    end

    conv_mac_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_vld    (w_rd_en),
        .i_data   (bus.data_rdata),
        .i_weight (bus.weight_rdata),
        .o_vld_p0 (w_vld_p0),
        .o_vld_p1 (w_vld_p1),
        .o_acc    (w_acc)
    );

    assign bus.buf_rd_en   = w_rd_en;
    assign bus.buf_rd_addr = r_cnt;
    assign bus.SUM         = r_sum;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: table of dot-product vectors, hand-written start/size/reset
// sequences and random runs checked against an arithmetic dot-product model.
module tb_conv_mac_engine;
    import conv_pkg::*;

    typedef struct packed {
        int             size;
        logic [3:0][7:0] d;
        logic [3:0][7:0] w;
        int             exp_sum;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_mac_engine_if bus ();

    conv_mac_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    logic signed [7:0] dmem [128];
    logic signed [7:0] wmem [128];
    int rd_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Operand buffers: one-cycle read latency
    always @(posedge clk) begin
        if (bus.buf_rd_en === 1'b1) begin
            bus.data_rdata   <= dmem[bus.buf_rd_addr];
            bus.weight_rdata <= wmem[bus.buf_rd_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.buf_rd_en === 1'b1) rd_q.push_back(int'(bus.buf_rd_addr));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int size, input int d0, input int d1, input int d2,
                                input int d3, input int w0, input int w1, input int w2,
                                input int w3, input int exp_sum);
        vec_t v;
        v.size    = size;
        v.d       = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        v.w       = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
        v.exp_sum = exp_sum;
        return v;
    endfunction

    function automatic int ref_dot(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(dmem[i]) * int'(wmem[i]);
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 128; i++) begin
            dmem[i] = 8'($urandom());
            wmem[i] = 8'($urandom());
        end
    endtask

    // Issues a 0->1 edge on CONTROL[0] (upper bits random) and waits for done.
    // lat is the cycle in which done is first seen, start_pulse cycle being 0.
    task automatic run(input int n, input int late_size, input bit retrig, output int lat);
        logic [31:0] ctrl;
        ctrl     = $urandom();
        ctrl[0]  = 1'b0;
        bus.SIZE = 7'(n);
        bus.CONTROL = ctrl;
        @(negedge clk);
        rd_q.delete();
        ctrl[0] = 1'b1;
        bus.CONTROL = ctrl;
        lat = -1;
        for (int k = 1; k <= n + 12; k++) begin
            @(negedge clk);
            if (k == 1 && n > 0) chk("busy_rise_done_clear", {bus.busy, bus.done}, 2'b10);
            if (k == n + 3 && n > 0) chk("busy_last_cycle", bus.busy, 1);
            if (late_size >= 0 && k == 2) bus.SIZE = 7'(late_size);
            if (retrig && k == 2) bus.CONTROL[0] = 1'b0;
            if (retrig && k == 3) bus.CONTROL[0] = 1'b1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int n_reads, input int exp_lat,
                                input int lat, input int exp_sum);
        int bad = 0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_sum"}, int'(bus.SUM), exp_sum);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
        chk({tag, "_read_count"}, rd_q.size(), n_reads);
        foreach (rd_q[i]) if (rd_q[i] != i) bad++;
        chk({tag, "_addr_order_errors"}, bad, 0);
    endtask

    vec_t tbl[7];

    initial begin
        int lat;
        int e;

        tbl[0] = mk(4,    1,    2,    3,    4,    5,    6,    7,    8,  70);
        tbl[1] = mk(127, -128, -128, -128, -128, -128, -128, -128, -128, 2080768);
        tbl[2] = mk(2,   -128,  127,    0,    0,  127,  127,    0,    0, -127);
        tbl[3] = mk(0,      9,    9,    9,    9,    9,    9,    9,    9, 0);
        tbl[4] = mk(1,    127,    0,    0,    0, -128,    0,    0,    0, -16256);
        tbl[5] = mk(5,      1,   -1,    2,   -2,    3,    3,    3,    3, 3);
        tbl[6] = mk(9,     10,  -20,   30,  -40,    7,    7,   -7,   -7, 70);

        bus.SIZE    = '0;
        bus.CONTROL = '0;
        fill_random();
        repeat (3) @(negedge clk);
        chk("reset_sum", bus.SUM, 0);
        chk("reset_busy_done", {bus.busy, bus.done}, 2'b00);
        chk("reset_rd_en_addr", {bus.buf_rd_en, bus.buf_rd_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven runs, each started from the previous DONE
        foreach (tbl[t]) begin
            for (int i = 0; i < 128; i++) begin
                dmem[i] = tbl[t].d[i % 4];
                wmem[i] = tbl[t].w[i % 4];
            end
            run(tbl[t].size, -1, 1'b0, lat);
            check_result($sformatf("table%0d", t), tbl[t].size,
                         (tbl[t].size == 0) ? 1 : tbl[t].size + 4, lat, tbl[t].exp_sum);
        end

        // CONTROL held high after completion must not restart
        rd_q.delete();
        repeat (10) @(negedge clk);
        chk("held_ctrl_no_reads", rd_q.size(), 0);
        chk("held_ctrl_done_busy", {bus.done, bus.busy}, 2'b10);
        chk("held_ctrl_sum", int'(bus.SUM), 70);

        // Second edge while busy is ignored
        fill_random();
        run(6, -1, 1'b1, lat);
        check_result("retrig_busy", 6, 10, lat, ref_dot(6));
        rd_q.delete();
        repeat (8) @(negedge clk);
        chk("retrig_no_second_run", rd_q.size(), 0);

        // SIZE changed mid-run has no effect
        fill_random();
        run(4, 9, 1'b0, lat);
        check_result("size_change", 4, 8, lat, ref_dot(4));

        // Asynchronous reset during FETCH of a 10-element run
        fill_random();
        bus.SIZE    = 7'd10;
        bus.CONTROL = '0;
        @(negedge clk);
        bus.CONTROL = 32'h1;
        repeat (3) @(negedge clk);
        chk("pre_reset_fetching", bus.buf_rd_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sum", bus.SUM, 0);
        chk("async_rst_busy_done", {bus.busy, bus.done}, 2'b00);
        chk("async_rst_rd_en", bus.buf_rd_en, 0);
        @(negedge clk);
        bus.CONTROL = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(3, -1, 1'b0, lat);
        check_result("after_reset", 3, 7, lat, ref_dot(3));

        // Random runs against the arithmetic model
        for (int r = 0; r < 8; r++) begin
            int n;
            n = (r == 0) ? 127 : int'($urandom_range(1, 60));
            fill_random();
            e = ref_dot(n);
            run(n, -1, 1'b0, lat);
            check_result($sformatf("rand%0d_n%0d", r, n), n, n + 4, lat, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
